sprite_mover: RTL and testbench

- Parametrised keyboard-driven sprite position controller; next generation of the single-ball mover.
- Sits between the USB keycode register and the color mapper; one update per frame_clk (vsync) edge.
- Adds configurable bounds, size and step, hold-to-accelerate speed, and a selectable edge mode (bounce/stop/wrap).
- Position update uses the same-frame resolved velocity, so the stale-velocity overshoot at walls and on keypresses is eliminated.

---
 rtl/sprite_pkg.sv | 55 +++++
 rtl/sprite_speed_ctrl.sv | 51 +++++
 rtl/sprite_mover.sv | 141 ++++++++++++++
 tb/tb_sprite_mover.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite mover: direction encoding,
// USB keycodes, edge-handling modes and keycode/direction helpers.
package sprite_pkg;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_STOP  = 8'h2C;

  localparam int EDGE_BOUNCE = 0;
  localparam int EDGE_STOP   = 1;
  localparam int EDGE_WRAP   = 2;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } key_dec_t;

  function automatic key_dec_t key_decode(input logic [7:0] k);
    key_dec_t r;
    r.hit = 1'b1;
    r.dir = STOP;
    case (k)
      KEY_UP:    r.dir = UP;
      KEY_DOWN:  r.dir = DOWN;
      KEY_LEFT:  r.dir = LEFT;
      KEY_RIGHT: r.dir = RIGHT;
      KEY_STOP:  r.dir = STOP;
      default:   r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic dir_t dir_reverse(input dir_t d);
    dir_t r;
    case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      RIGHT:   r = LEFT;
      default: r = STOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sprite_speed_ctrl.sv
// Hold-to-accelerate speed control. speed_key_o is this frame's resolved
// speed (used combinationally by the mover); force_i reloads STEP next edge.
module sprite_speed_ctrl #(
  parameter int W            = 10,
  parameter int STEP         = 1,
  parameter int STEP_MAX     = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic         clk_i,
  input  logic         match_i,
  input  logic         chg_i,
  input  logic         force_i,
  output logic [W-1:0] speed_key_o,
  output logic [W-1:0] speed_o
);

  localparam logic [W-1:0] STEP_W     = W'(STEP);
  localparam logic [W-1:0] STEP_MAX_W = W'(STEP_MAX);
  localparam logic [7:0]   HOLD_LAST  = 8'(ACCEL_FRAMES - 1);

  logic [7:0]   hold_q, hold_d;
  logic [W-1:0] speed_q, speed_d;

  always_comb begin
    hold_d  = '0;
    speed_d = speed_q;
    if (chg_i) begin
      speed_d = STEP_W;
    end else if (match_i) begin
      if (hold_q == HOLD_LAST) begin
        speed_d = (speed_q >= STEP_MAX_W) ? STEP_MAX_W : speed_q + 1'b1;
      end else begin
        hold_d = hold_q + 8'd1;
      end
    end
  end

  assign speed_key_o = speed_d;
  assign speed_o     = speed_q;

  always_ff @(posedge clk_i) begin
    if (force_i) begin
      hold_q  <= '0;
      speed_q <= STEP_W;
    end else begin
      hold_q  <= hold_d;
      speed_q <= speed_d;
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// Keyboard-driven sprite position controller, one update per frame_clk edge.
// Optional SPRITE_BOUNCE_CNT_EN adds a saturating edge-event counter output.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int W            = 10,
  parameter int X_CENTER     = 300,
  parameter int Y_CENTER     = 250,
  parameter int X_MIN        = 50,
  parameter int X_MAX        = 600,
  parameter int Y_MIN        = 50,
  parameter int Y_MAX        = 400,
  parameter int SIZE         = 4,
  parameter int STEP         = 1,
  parameter int STEP_MAX     = 4,
  parameter int ACCEL_FRAMES = 8,
  parameter int EDGE_MODE    = 0
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [7:0]   key,
  output logic [W-1:0] SpriteX,
  output logic [W-1:0] SpriteY,
  output logic [W-1:0] SpriteS,
  output dir_t         Dir,
  output logic [W-1:0] Speed
`ifdef SPRITE_BOUNCE_CNT_EN
  ,
  output logic [7:0]   BounceCnt
`endif
);

  localparam logic signed [W:0] X_MIN_S = signed'((W+1)'(X_MIN));
  localparam logic signed [W:0] X_MAX_S = signed'((W+1)'(X_MAX));
  localparam logic signed [W:0] Y_MIN_S = signed'((W+1)'(Y_MIN));
  localparam logic signed [W:0] Y_MAX_S = signed'((W+1)'(Y_MAX));
  localparam logic signed [W:0] SIZE_S  = signed'((W+1)'(SIZE));
  localparam logic signed [W:0] ONE_S   = signed'((W+1)'(1));

  logic [W-1:0] x_q, x_d, y_q, y_d;
  dir_t         dir_q, dir_d, key_dir;
  key_dec_t     kd;
  logic         key_match, key_chg, edge_stop, speed_force;
  logic [W-1:0] speed_key, speed_reg;

  logic              horiz, pos_inc, moving, hi_hit, lo_hit;
  logic signed [W:0] pos_s, spd_s, nxt_s, lo_s, hi_s, res_s;

  // Key stage: STOP==STOP is not a "match", so it never accelerates.
  assign kd          = key_decode(key);
  assign key_match   = kd.hit && (kd.dir == dir_q) && (dir_q != STOP);
  assign key_chg     = kd.hit && (kd.dir != dir_q);
  assign key_dir     = kd.hit ? kd.dir : dir_q;
  assign speed_force = Reset | edge_stop;

  sprite_speed_ctrl #(
    .W            (W),
    .STEP         (STEP),
    .STEP_MAX     (STEP_MAX),
    .ACCEL_FRAMES (ACCEL_FRAMES)
  ) u_speed (
    .clk_i       (frame_clk),
    .match_i     (key_match),
    .chg_i       (key_chg),
    .force_i     (speed_force),
    .speed_key_o (speed_key),
    .speed_o     (speed_reg)
  );

  // Move stage uses the key-stage direction and speed of the same frame.
  always_comb begin
    horiz     = (key_dir == LEFT) || (key_dir == RIGHT);
    pos_inc   = (key_dir == RIGHT) || (key_dir == DOWN);
    moving    = (key_dir != STOP);
    pos_s     = horiz ? {1'b0, x_q} : {1'b0, y_q};
    spd_s     = {1'b0, speed_key};
    lo_s      = horiz ? X_MIN_S : Y_MIN_S;
    hi_s      = horiz ? X_MAX_S : Y_MAX_S;
    nxt_s     = pos_inc ? pos_s + spd_s : pos_s - spd_s;
    hi_hit    = moving && pos_inc && (nxt_s + SIZE_S >= hi_s);
    lo_hit    = moving && !pos_inc && (nxt_s - SIZE_S <= lo_s);
    res_s     = nxt_s;
    dir_d     = key_dir;
    edge_stop = 1'b0;
    if (hi_hit || lo_hit) begin
      case (EDGE_MODE)
        EDGE_BOUNCE: begin
          res_s = hi_hit ? hi_s - SIZE_S : lo_s + SIZE_S;
          dir_d = dir_reverse(key_dir);
        end
        EDGE_STOP: begin
          res_s     = hi_hit ? hi_s - SIZE_S : lo_s + SIZE_S;
          dir_d     = STOP;
          edge_stop = 1'b1;
        end
        default: begin
          res_s = hi_hit ? lo_s + SIZE_S + ONE_S : hi_s - SIZE_S - ONE_S;
        end
      endcase
    end
    x_d = x_q;
    y_d = y_q;
    if (moving) begin
      if (horiz) x_d = res_s[W-1:0];
      else       y_d = res_s[W-1:0];
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      x_q   <= W'(X_CENTER);
      y_q   <= W'(Y_CENTER);
      dir_q <= STOP;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
    end
  end

  assign SpriteX = x_q;
  assign SpriteY = y_q;
  assign SpriteS = W'(SIZE);
  assign Dir     = dir_q;
  assign Speed   = speed_reg;

`ifdef SPRITE_BOUNCE_CNT_EN
  logic [7:0] bcnt_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      bcnt_q <= '0;
    end else if ((hi_hit || lo_hit) && (bcnt_q != 8'hFF)) begin
      bcnt_q <= bcnt_q + 8'd1;
    end
  end

  assign BounceCnt = bcnt_q;
`endif

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: three instances (bounce/stop/wrap) driven by shared
// directed keys, checked each frame against a behavioural model plus literals.
module tb_sprite_mover;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] key;

  logic [9:0] sx [3];
  logic [9:0] sy [3];
  logic [9:0] ss [3];
  logic [9:0] sp [3];
  logic [2:0] sd [3];
`ifdef SPRITE_BOUNCE_CNT_EN
  logic [7:0] bc [3];
`endif

  sprite_mover #(.EDGE_MODE(0)) u_bnc (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .key       (key),
    .SpriteX   (sx[0]),
    .SpriteY   (sy[0]),
    .SpriteS   (ss[0]),
    .Dir       (sd[0]),
    .Speed     (sp[0])
`ifdef SPRITE_BOUNCE_CNT_EN
    ,
    .BounceCnt (bc[0])
`endif
  );

  sprite_mover #(.EDGE_MODE(1)) u_stp (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .key       (key),
    .SpriteX   (sx[1]),
    .SpriteY   (sy[1]),
    .SpriteS   (ss[1]),
    .Dir       (sd[1]),
    .Speed     (sp[1])
`ifdef SPRITE_BOUNCE_CNT_EN
    ,
    .BounceCnt (bc[1])
`endif
  );

  sprite_mover #(.EDGE_MODE(2)) u_wrp (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .key       (key),
    .SpriteX   (sx[2]),
    .SpriteY   (sy[2]),
    .SpriteS   (ss[2]),
    .Dir       (sd[2]),
    .Speed     (sp[2])
`ifdef SPRITE_BOUNCE_CNT_EN
    ,
    .BounceCnt (bc[2])
`endif
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int nchecks = 0;
  int nerrors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: plain integers, one entry per edge mode.
  int mx [3], my [3], md [3], ms [3], mh [3], mbc [3];
  bit mvalid = 1'b0;

  function automatic int key_dir_of(input logic [7:0] k);
    case (k)
      8'h52:   return 1;
      8'h51:   return 2;
      8'h50:   return 3;
      8'h4F:   return 4;
      8'h2C:   return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int opposite(input int d);
    case (d)
      1:       return 2;
      2:       return 1;
      3:       return 4;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step(input int m);
    int  kd, pos, nxt, lo, hi;
    bit  horiz, inc;
    if (Reset) begin
      mx[m] = 300; my[m] = 250; md[m] = 0; ms[m] = 1; mh[m] = 0; mbc[m] = 0;
      return;
    end
    kd = key_dir_of(key);
    if (kd >= 0) begin
      if (kd != md[m]) begin
        md[m] = kd; ms[m] = 1; mh[m] = 0;
      end else if (kd == 0) begin
        mh[m] = 0;
      end else if (mh[m] == 7) begin
        mh[m] = 0;
        ms[m] = (ms[m] + 1 > 4) ? 4 : ms[m] + 1;
      end else begin
        mh[m] = mh[m] + 1;
      end
    end else begin
      mh[m] = 0;
    end
    if (md[m] == 0) return;
    horiz = (md[m] == 3) || (md[m] == 4);
    inc   = (md[m] == 2) || (md[m] == 4);
    pos   = horiz ? mx[m] : my[m];
    lo    = 50;
    hi    = horiz ? 600 : 400;
    nxt   = inc ? pos + ms[m] : pos - ms[m];
    if ((inc && nxt + 4 >= hi) || (!inc && nxt - 4 <= lo)) begin
      if (mbc[m] < 255) mbc[m] = mbc[m] + 1;
      if (m == 0) begin
        nxt = inc ? hi - 4 : lo + 4;
        md[m] = opposite(md[m]);
      end else if (m == 1) begin
        nxt = inc ? hi - 4 : lo + 4;
        md[m] = 0; ms[m] = 1; mh[m] = 0;
      end else begin
        nxt = inc ? lo + 5 : hi - 5;
      end
    end
    if (horiz) mx[m] = nxt;
    else       my[m] = nxt;
  endfunction

  always @(posedge frame_clk) begin
    if (Reset) mvalid = 1'b1;
    for (int m = 0; m < 3; m++) model_step(m);
  end

  always @(negedge frame_clk) begin
    if (mvalid) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("m%0d X", m),     int'(sx[m]), mx[m]);
        chk($sformatf("m%0d Y", m),     int'(sy[m]), my[m]);
        chk($sformatf("m%0d S", m),     int'(ss[m]), 4);
        chk($sformatf("m%0d Dir", m),   int'(sd[m]), md[m]);
        chk($sformatf("m%0d Speed", m), int'(sp[m]), ms[m]);
`ifdef SPRITE_BOUNCE_CNT_EN
        chk($sformatf("m%0d BounceCnt", m), int'(bc[m]), mbc[m]);
`endif
      end
    end
  end

  task automatic frame(input logic [7:0] k);
    key = k;
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic frames(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) frame(k);
  endtask

  task automatic do_reset(input logic [7:0] k);
    Reset = 1'b1;
    frame(k);
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    key   = 8'h00;

    // Reset state
    do_reset(8'h00);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst m%0d X", m), int'(sx[m]), 300);
      chk($sformatf("rst m%0d Y", m), int'(sy[m]), 250);
      chk($sformatf("rst m%0d Dir", m), int'(sd[m]), 0);
      chk($sformatf("rst m%0d Speed", m), int'(sp[m]), 1);
    end

    // Same-frame velocity on a single keypress
    frame(8'h4F);
    chk("tap X1", int'(sx[0]), 301);
    chk("tap Dir", int'(sd[0]), 4);
    frame(8'h00);
    chk("tap X2", int'(sx[0]), 302);
    frame(8'h00);
    chk("tap X3", int'(sx[0]), 303);
    frames(8'h00, 117);
    chk("pre-reset X", int'(sx[0]), 420);

    // Reset mid-motion with a key also pressed
    do_reset(8'h4F);
    chk("midrst X", int'(sx[0]), 300);
    chk("midrst Y", int'(sy[0]), 250);
    chk("midrst Dir", int'(sd[0]), 0);
    chk("midrst Speed", int'(sp[0]), 1);

    // Hold-to-accelerate and speed ceiling
    frames(8'h4F, 8);
    chk("accel f8 X", int'(sx[0]), 308);
    chk("accel f8 Speed", int'(sp[0]), 1);
    frame(8'h4F);
    chk("accel f9 X", int'(sx[0]), 310);
    chk("accel f9 Speed", int'(sp[0]), 2);
    frames(8'h4F, 24);
    chk("accel f33 X", int'(sx[0]), 384);
    chk("accel f33 Speed", int'(sp[0]), 4);

    // Unmapped key keeps direction/speed; STOP key halts
    frame(8'h04);
    chk("unmapped X", int'(sx[0]), 388);
    chk("unmapped Speed", int'(sp[0]), 4);
    frame(8'h2C);
    chk("stopkey X", int'(sx[0]), 388);
    chk("stopkey Dir", int'(sd[0]), 0);
    chk("stopkey Speed", int'(sp[0]), 1);
    frame(8'h2C);
    chk("stopkey2 X", int'(sx[0]), 388);

    // Right wall, key released: bounce / stop / wrap
    do_reset(8'h00);
    frame(8'h4F);
    frames(8'h00, 294);
    chk("rwall pre X", int'(sx[0]), 595);
    frame(8'h00);
    chk("rwall bnc X", int'(sx[0]), 596);
    chk("rwall bnc Dir", int'(sd[0]), 3);
    chk("rwall stp X", int'(sx[1]), 596);
    chk("rwall stp Dir", int'(sd[1]), 0);
    chk("rwall wrp X", int'(sx[2]), 55);
    chk("rwall wrp Dir", int'(sd[2]), 4);
    frame(8'h00);
    chk("rwall bnc X+1", int'(sx[0]), 595);
    chk("rwall stp X+1", int'(sx[1]), 596);
    chk("rwall wrp X+1", int'(sx[2]), 56);

    // Right wall with key held into it: edge overrides key
    do_reset(8'h00);
    frame(8'h4F);
    frames(8'h00, 294);
    frame(8'h4F);
    chk("rwall key X", int'(sx[0]), 596);
    chk("rwall key Dir", int'(sd[0]), 3);
    frame(8'h00);
    chk("rwall key X+1", int'(sx[0]), 595);

    // Left wall: wrap
    do_reset(8'h00);
    frame(8'h50);
    chk("left X1", int'(sx[2]), 299);
    frames(8'h00, 244);
    chk("lwall pre X", int'(sx[2]), 55);
    frame(8'h00);
    chk("lwall wrp X", int'(sx[2]), 595);
    chk("lwall wrp Dir", int'(sd[2]), 3);
    chk("lwall bnc X", int'(sx[0]), 54);
    chk("lwall bnc Dir", int'(sd[0]), 4);
    frame(8'h00);
    chk("lwall wrp X+1", int'(sx[2]), 594);
    chk("lwall bnc X+1", int'(sx[0]), 55);

    // Bottom wall: stop
    do_reset(8'h00);
    frame(8'h51);
    frames(8'h00, 144);
    chk("bwall pre Y", int'(sy[1]), 395);
    frame(8'h00);
    chk("bwall stp Y", int'(sy[1]), 396);
    chk("bwall stp Dir", int'(sd[1]), 0);
    chk("bwall stp Speed", int'(sp[1]), 1);
    chk("bwall bnc Dir", int'(sd[0]), 1);
`ifdef SPRITE_BOUNCE_CNT_EN
    chk("bwall stp BounceCnt", int'(bc[1]), 1);
`endif
    frame(8'h00);
    chk("bwall stp Y+1", int'(sy[1]), 396);
    chk("bwall bnc Y+1", int'(sy[0]), 395);
    frame(8'h52);
    chk("up after stop Y", int'(sy[1]), 395);
    chk("up after stop Dir", int'(sd[1]), 1);
    frames(8'h00, 3);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
